change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 203 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount as physical coins. The amount is broken down
// greedily into high / mid / low (value 1) coins, skipping hoppers that are
// empty or that have jammed during this transaction. Each coin gets one eject
// pulse of PULSE_CYCLES cycles, and the coin sensor must confirm it before the
// next coin is selected. Completion or failure is reported as a one-cycle pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   change_amount[4:0]  amount to pay, sampled when change_valid & change_ready
//   change_valid        request strobe (ignored while busy)
//   change_ready        high only while idle
//   hopper_empty[2:0]   [2]=hi [1]=mid [0]=lo, 1 = hopper has no coins
//   coin_sensed         one-cycle pulse per coin seen by the sensor
//   eject_hi/mid/lo     registered solenoid drives, at most one high at a time
//   busy                high whenever a transaction is in progress
//   remaining[4:0]      amount still owed (unpaid amount after an error)
//   coins_out[4:0]      coins paid in this transaction, saturating at 31
//   dispense_done       one-cycle pulse, the cycle after the DONE state
//   dispense_error      one-cycle pulse, the cycle after the ERROR state
module change_dispenser #(
  parameter int D_HI         = 10,
  parameter int D_MID        = 5,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] change_amount,
  input  logic       change_valid,
  output logic       change_ready,
  input  logic [2:0] hopper_empty,
  input  logic       coin_sensed,
  output logic       eject_hi,
  output logic       eject_mid,
  output logic       eject_lo,
  output logic       busy,
  output logic [4:0] remaining,
  output logic [4:0] coins_out,
  output logic       dispense_done,
  output logic       dispense_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_DONE, S_ERROR
  } state_t;

  // Denomination values packed as {hi, mid, lo}, matching hopper_empty bit order.
  localparam logic [14:0] DENOM_VEC = {5'(D_HI), 5'(D_MID), 5'd1};

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [4:0]    remaining_reg;
  logic [4:0]    coins_reg;
  logic [2:0]    jam_reg;
  logic          seen_reg;
  logic [2:0]    sel_reg;
  logic [4:0]    d_reg;
  logic [2:0]    eject_reg;
  logic [PW-1:0] pulse_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          done_reg;
  logic          error_reg;

  logic [2:0] avail;
  logic [2:0] sel_next;
  logic [4:0] d_next;
  logic [4:0] remaining_sub;
  logic       pulse_last;
  logic       ack;
  logic       timeout;

  // A denomination qualifies when it fits in what is still owed, its hopper
  // is not empty and it has not jammed since the last accept.
  for (genvar gi = 0; gi < 3; gi++) begin : g_avail
    assign avail[gi] = ~hopper_empty[gi] & ~jam_reg[gi] &
                       (remaining_reg >= DENOM_VEC[gi*5 +: 5]);
  end

  always_comb begin
    sel_next = 3'b000;
    d_next   = 5'd0;
    if (avail[2]) begin
      sel_next = 3'b100;
      d_next   = DENOM_VEC[14:10];
    end else if (avail[1]) begin
      sel_next = 3'b010;
      d_next   = DENOM_VEC[9:5];
    end else if (avail[0]) begin
      sel_next = 3'b001;
      d_next   = DENOM_VEC[4:0];
    end
  end

  // d_reg was checked against remaining in SELECT, so this cannot underflow.
  assign remaining_sub = remaining_reg - d_reg;
  assign pulse_last    = (pulse_cnt_reg == PULSE_LAST);
  // A sensor pulse that arrived while the solenoid was still firing counts too.
  assign ack           = coin_sensed | seen_reg;
  assign timeout       = (to_cnt_reg == ACK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (change_valid) state_next = (change_amount == 5'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: begin
        state_next = (sel_next != 3'b000) ? S_EJECT : S_ERROR;
      end
      S_EJECT: begin
        if (pulse_last) state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack)          state_next = (remaining_sub == 5'd0) ? S_DONE : S_SELECT;
        else if (timeout) state_next = S_SELECT;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERROR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_reg <= '0;
      coins_reg     <= '0;
      jam_reg       <= '0;
      seen_reg      <= 1'b0;
      sel_reg       <= '0;
      d_reg         <= '0;
      eject_reg     <= '0;
      pulse_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg  <= (state_reg == S_DONE);
      error_reg <= (state_reg == S_ERROR);
      case (state_reg)
        S_IDLE: begin
          if (change_valid) begin
            remaining_reg <= change_amount;
            coins_reg     <= '0;
            jam_reg       <= '0;
            seen_reg      <= 1'b0;
          end
        end
        S_SELECT: begin
          seen_reg      <= 1'b0;
          pulse_cnt_reg <= '0;
          if (sel_next != 3'b000) begin
            sel_reg   <= sel_next;
            d_reg     <= d_next;
            eject_reg <= sel_next;
          end
        end
        S_EJECT: begin
          if (coin_sensed) seen_reg <= 1'b1;
          if (pulse_last) begin
            eject_reg  <= '0;
            to_cnt_reg <= '0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + PW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack) begin
            remaining_reg <= remaining_sub;
            if (coins_reg != 5'd31) coins_reg <= coins_reg + 5'd1;
            seen_reg <= 1'b0;
          end else if (timeout) begin
            // Jam is sticky until the next accept; remaining is untouched.
            jam_reg <= jam_reg | sel_reg;
          end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign change_ready   = (state_reg == S_IDLE);
  assign busy           = (state_reg != S_IDLE);
  assign eject_hi       = eject_reg[2];
  assign eject_mid      = eject_reg[1];
  assign eject_lo       = eject_reg[0];
  assign remaining      = remaining_reg;
  assign coins_out      = coins_reg;
  assign dispense_done  = done_reg;
  assign dispense_error = error_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios followed by randomized
// transactions, all checked against a coin-level reference model (greedy
// denomination choice, jam bookkeeping and handshake timing).
module tb_change_dispenser;
  localparam int P   = 4;
  localparam int ACK = 16;
  localparam int DH  = 10;
  localparam int DM  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] change_amount = '0;
  logic       change_valid = 1'b0;
  logic       change_ready;
  logic [2:0] hopper_empty = '0;
  logic       coin_sensed = 1'b0;
  logic       eject_hi, eject_mid, eject_lo;
  logic       busy;
  logic [4:0] remaining;
  logic [4:0] coins_out;
  logic       dispense_done;
  logic       dispense_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser #(.D_HI(DH), .D_MID(DM), .PULSE_CYCLES(P), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n),
    .change_amount(change_amount), .change_valid(change_valid),
    .change_ready(change_ready), .hopper_empty(hopper_empty),
    .coin_sensed(coin_sensed),
    .eject_hi(eject_hi), .eject_mid(eject_mid), .eject_lo(eject_lo),
    .busy(busy), .remaining(remaining), .coins_out(coins_out),
    .dispense_done(dispense_done), .dispense_error(dispense_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Value of a one-hot denomination {hi, mid, lo}.
  function automatic int dval(input logic [2:0] oh);
    if (oh[2]) return DH;
    if (oh[1]) return DM;
    return 1;
  endfunction

  // Largest usable coin for the amount owed, or 0 if none can be paid.
  function automatic logic [2:0] pick(input int rem, input logic [2:0] empty, input logic [2:0] jam);
    if (!empty[2] && !jam[2] && rem >= DH) return 3'b100;
    if (!empty[1] && !jam[1] && rem >= DM) return 3'b010;
    if (!empty[0] && !jam[0] && rem >= 1)  return 3'b001;
    return 3'b000;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, change_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ejects"}, {eject_hi, eject_mid, eject_lo}, 0);
    check({tag, "_remaining"}, remaining, 0);
    check({tag, "_coins"}, coins_out, 0);
    check({tag, "_pulses"}, {dispense_done, dispense_error}, 0);
  endtask

  // One full transaction. miss_mask bit i = the i-th eject is never sensed.
  // fixed_off >= 0 places the sensor pulse that many cycles after eject rise,
  // otherwise the offset is random within the acknowledge window.
  task automatic run_txn(input string tag, input logic [4:0] amt, input logic [2:0] empty,
                         input logic [63:0] miss_mask, input int fixed_off,
                         input bit rnd_valid, input int exp_coins);
    int rem, coins, idx, n, base, width, off, soff, d;
    logic [2:0] jam, prev_ej, cur, ej, exp_sel;
    bit sensed, finished;
    rem = amt; coins = 0; idx = 0; n = 0; base = 1; width = 0; off = 0; soff = 0;
    jam = '0; prev_ej = '0; cur = '0; sensed = 1'b0; finished = 1'b0;

    @(negedge clk);
    check({tag, "_ready_before"}, change_ready, 1);
    hopper_empty  = empty;
    change_amount = amt;
    change_valid  = 1'b1;

    while (!finished && n < 2000) begin
      @(negedge clk);
      n++;
      change_valid = 1'b0;
      coin_sensed  = 1'b0;
      ej = {eject_hi, eject_mid, eject_lo};
      if (n == 1) check({tag, "_busy_after_accept"}, busy, 1);

      if (ej != 3'b000 && prev_ej == 3'b000) begin
        exp_sel = pick(rem, empty, jam);
        check($sformatf("%s_coin%0d_sel", tag, idx), ej, exp_sel);
        check($sformatf("%s_coin%0d_start", tag, idx), n, base + 1);
        cur = ej; width = 1; off = 0;
        sensed = (idx < 64) ? !miss_mask[idx] : 1'b1;
        soff = (fixed_off >= 0) ? fixed_off : int'($urandom_range(0, P + ACK - 1));
        d = dval((exp_sel != 3'b000) ? exp_sel : ej);
        idx++;
        if (sensed) begin
          rem -= d;
          coins++;
          base = n + ((soff > P) ? soff : P) + 1;
        end else begin
          jam |= (exp_sel != 3'b000) ? exp_sel : ej;
          base = n + P + ACK;
        end
      end else if (ej != 3'b000) begin
        width++; off++;
        if (ej !== cur) check({tag, "_eject_stable"}, ej, cur);
      end else begin
        if (prev_ej != 3'b000) check($sformatf("%s_coin%0d_width", tag, idx - 1), width, P);
        off++;
      end

      if (idx > 0 && sensed && off == soff) coin_sensed = 1'b1;

      if (dispense_done || dispense_error) begin
        check({tag, "_outcome"}, {dispense_done, dispense_error},
              {rem == 0, rem != 0 && pick(rem, empty, jam) == 3'b000});
        check({tag, "_outcome_time"}, n, dispense_done ? base + 1 : base + 2);
        check({tag, "_remaining"}, remaining, 32'(rem));
        check({tag, "_coins"}, coins_out, 32'(coins));
        if (exp_coins >= 0) check({tag, "_coins_plan"}, coins_out, 32'(exp_coins));
        check({tag, "_ready_end"}, change_ready, 1);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        check({tag, "_pulse_width"}, {dispense_done, dispense_error}, 0);
        finished = 1'b1;
      end else begin
        prev_ej = ej;
        if (rnd_valid && busy) begin
          change_valid  = ($urandom_range(0, 3) == 0);
          change_amount = 5'($urandom);
        end
      end
    end
    change_valid = 1'b0;
    coin_sensed  = 1'b0;
    check({tag, "_completed"}, finished, 1);
    $display("txn %s amount=%0d empty=%b coins=%0d remaining=%0d cycles=%0d",
             tag, amt, empty, coins_out, remaining, n);
  endtask

  initial begin
    bit found;
    logic [63:0] mm;
    logic [2:0] emp;

    // Power-on reset
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");

    // Directed scenarios
    run_txn("amt18", 5'd18, 3'b000, 64'd0, 5, 1'b0, 5);
    run_txn("amt0", 5'd0, 3'b000, 64'd0, 5, 1'b0, 0);
    run_txn("amt7_nomid", 5'd7, 3'b010, 64'd0, 5, 1'b0, 7);
    run_txn("amt12_hijam", 5'd12, 3'b000, 64'd1, 5, 1'b0, 4);
    run_txn("amt3_nolo", 5'd3, 3'b001, 64'd0, 5, 1'b0, 0);

    // Reset during the second cycle of a hi eject
    @(negedge clk);
    hopper_empty = 3'b000; change_amount = 5'd18; change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (eject_hi) found = 1'b1;
    end
    check("rst_hi_started", found, 1);
    @(negedge clk);
    check("rst_hi_second_cycle", eject_hi, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_eject_drop", eject_hi, 0);
    check("rst_async_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid_txn");
    run_txn("amt6_after_rst", 5'd6, 3'b000, 64'd0, 5, 1'b0, 2);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      mm = '0;
      for (int b = 0; b < 64; b++) mm[b] = ($urandom_range(0, 7) == 0);
      emp = '0;
      for (int b = 0; b < 3; b++) emp[b] = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rnd%0d", t), 5'($urandom_range(0, 31)), emp, mm, -1, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
